// File: rtl/code_lock_fsm.sv
// Keypad code lock: edge-detected key entry, code check, pass/fail hold and failure lockout.
// Define CODE_PROG_EN to make the stored code reprogrammable (enter pressed while in PASS).
module code_lock_fsm #(
    parameter int unsigned           CODE_LEN    = 4,
    parameter logic [CODE_LEN*4-1:0] PWD         = 16'h2702,
    parameter int unsigned           MAX_FAIL    = 3,
    parameter int unsigned           LOCK_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            key_value,
    input  logic                  key_enable,
    output logic [CODE_LEN*4-1:0] digits,
    output logic [3:0]            entry_count,
    output logic                  Tout,
    output logic                  Fout,
    output logic                  locked_out,
    output logic [3:0]            fail_count
);

    localparam int unsigned       W        = CODE_LEN * 4;
    localparam int unsigned       TimerW   = $clog2(LOCK_CYCLES + 1);
    localparam logic [3:0]        CodeLenC = 4'(CODE_LEN);
    localparam logic [3:0]        MaxFailC = 4'(MAX_FAIL);
    localparam logic [TimerW-1:0] LockLoad = TimerW'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StEntry   = 3'd1,
        StCheck   = 3'd2,
        StPass    = 3'd3,
        StFail    = 3'd4,
        StLockout = 3'd5,
        StProg    = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      digits_q, digits_d, entry_digits, code_cur;
    logic [3:0]        count_q, count_d, entry_cnt;
    logic [3:0]        fails_q, fails_d;
    logic              tout_q, tout_d, fout_q, fout_d, lock_q, lock_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              key_q, armed_q;
    logic              press, is_digit, is_clear, is_enter, is_action, buf_full;

`ifdef CODE_PROG_EN
    logic [W-1:0] code_q, code_d;
    assign code_cur = code_q;
`else
    assign code_cur = PWD;
`endif

    // armed_q masks the first cycle after reset so a key held through reset is not a press
    assign press     = key_enable & ~key_q & armed_q;
    assign is_digit  = key_value <= 4'd9;
    assign is_clear  = key_value == 4'd10;
    assign is_enter  = key_value == 4'd11;
    assign is_action = key_value <= 4'd11;
    assign buf_full  = count_q == CodeLenC;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            digits_q <= '0;
            count_q  <= '0;
            fails_q  <= '0;
            tout_q   <= 1'b0;
            fout_q   <= 1'b0;
            lock_q   <= 1'b0;
            timer_q  <= '0;
            key_q    <= 1'b0;
            armed_q  <= 1'b0;
`ifdef CODE_PROG_EN
            code_q   <= PWD;
`endif
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            count_q  <= count_d;
            fails_q  <= fails_d;
            tout_q   <= tout_d;
            fout_q   <= fout_d;
            lock_q   <= lock_d;
            timer_q  <= timer_d;
            key_q    <= key_enable;
            armed_q  <= 1'b1;
`ifdef CODE_PROG_EN
            code_q   <= code_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        count_d  = count_q;
        fails_d  = fails_q;
        tout_d   = tout_q;
        fout_d   = fout_q;
        lock_d   = lock_q;
        timer_d  = timer_q;
`ifdef CODE_PROG_EN
        code_d   = code_q;
`endif

        // Buffer edits shared by entry and programming modes
        entry_digits = digits_q;
        entry_cnt    = count_q;
        if (press && is_digit && !buf_full) begin
            for (int i = 0; i < int'(CODE_LEN); i++) begin
                if (count_q == 4'(i)) entry_digits[i*4 +: 4] = key_value;
            end
            entry_cnt = count_q + 4'd1;
        end else if (press && is_clear) begin
            entry_digits = '0;
            entry_cnt    = '0;
        end

        case (state_q)
            StIdle, StEntry: begin
                digits_d = entry_digits;
                count_d  = entry_cnt;
                if (press && is_enter && buf_full) state_d = StCheck;
                else state_d = (entry_cnt == 4'd0) ? StIdle : StEntry;
            end
            StCheck: begin
                if (digits_q == code_cur) begin
                    tout_d  = 1'b1;
                    fout_d  = 1'b0;
                    fails_d = '0;
                    state_d = StPass;
                end else if (({1'b0, fails_q} + 5'd1) < {1'b0, MaxFailC}) begin
                    tout_d  = 1'b0;
                    fout_d  = 1'b1;
                    fails_d = fails_q + 4'd1;
                    state_d = StFail;
                end else begin
                    tout_d  = 1'b0;
                    fout_d  = 1'b1;
                    fails_d = MaxFailC;
                    lock_d  = 1'b1;
                    timer_d = LockLoad;
                    state_d = StLockout;
                end
            end
            StPass, StFail: begin
                if (press && is_action) begin
                    digits_d = '0;
                    count_d  = '0;
`ifdef CODE_PROG_EN
                    if (state_q == StPass && is_enter) begin
                        state_d = StProg;
                    end else begin
                        tout_d  = 1'b0;
                        fout_d  = 1'b0;
                        state_d = StIdle;
                    end
`else
                    tout_d  = 1'b0;
                    fout_d  = 1'b0;
                    state_d = StIdle;
`endif
                end
            end
            StLockout: begin
                if (timer_q == '0) begin
                    lock_d   = 1'b0;
                    fout_d   = 1'b0;
                    fails_d  = '0;
                    digits_d = '0;
                    count_d  = '0;
                    state_d  = StIdle;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`ifdef CODE_PROG_EN
            StProg: begin
                digits_d = entry_digits;
                count_d  = entry_cnt;
                if (press && is_enter && buf_full) begin
                    code_d   = digits_q;
                    tout_d   = 1'b0;
                    digits_d = '0;
                    count_d  = '0;
                    state_d  = StIdle;
                end
            end
`endif
            default: begin
                state_d  = StIdle;
                digits_d = '0;
                count_d  = '0;
                fails_d  = '0;
                tout_d   = 1'b0;
                fout_d   = 1'b0;
                lock_d   = 1'b0;
                timer_d  = '0;
            end
        endcase
    end

    always_comb begin
        digits      = digits_q;
        entry_count = count_q;
        Tout        = tout_q;
        Fout        = fout_q;
        locked_out  = lock_q;
        fail_count  = fails_q;
    end

endmodule

// File: doc/code_lock_fsm.md
Name: code_lock_fsm

Overview:
Parametrised keypad code lock. It sits between the keypad scanner (value/enable pair) and the 7-segment display multiplexer. It generalises the fixed 4-digit password FSM in four ways: configurable code length, explicit clear/enter keys, press-edge detection, and a failure-count lockout with timeout. It drives pass/fail indicators and exposes the entry buffer for display.

Parameters:
CODE_LEN, 4, digits in code; legal 1..8
PWD, 16'h2702, packed code; digit i (i-th entered) at bits [4i+3:4i]; width CODE_LEN*4
MAX_FAIL, 3, consecutive failed checks that trigger lockout; legal 1..15
LOCK_CYCLES, 1024, lockout duration in clk cycles; must be >=1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
key_value  input  4  scanned key code: 0-9 digit, 10 clear, 11 enter, 12-15 ignored
key_enable  input  1  level, high while a key is held
digits  output  CODE_LEN*4  entry buffer; slot i at [4i+3:4i]
entry_count  output  4  digits entered so far (0..CODE_LEN)
Tout  output  1  code accepted
Fout  output  1  code rejected or lockout active
locked_out  output  1  lockout timer running
fail_count  output  4  consecutive failures

Behaviour:
- Clocking: one clock domain (clk); asynchronous active-low reset (rst).
- Reset: state=IDLE; digits=0; entry_count=0; Tout=0; Fout=0; locked_out=0; fail_count=0; key_d=0; timer=0.
- Press event: press = key_enable & ~key_d, where key_d is key_enable registered each cycle.
  - A held key yields exactly one event.
  - Release is not an event.
- Codes 12-15 produce no action in any state.
- IDLE/ENTRY (ENTRY whenever entry_count>0):
  - Digit 0-9 with entry_count<CODE_LEN: the digit is written to slot entry_count and entry_count increments, both on the press edge (visible 1 cycle after key_enable first sampled high).
  - Digit 0-9 with entry_count==CODE_LEN: ignored.
  - Clear (10): digits=0, entry_count=0, state=IDLE.
  - Enter (11) with entry_count==CODE_LEN: go to CHECK.
  - Enter (11) with entry_count<CODE_LEN: ignored.
- CHECK: one cycle. Compare digits against the stored code. Outputs update on the edge leaving CHECK, i.e. 2 cycles after the enter press edge.
  - Match: Tout=1, Fout=0, fail_count=0, go to PASS.
  - Mismatch with fail_count+1<MAX_FAIL: Fout=1, Tout=0, fail_count+1, go to FAIL.
  - Mismatch with fail_count+1==MAX_FAIL: fail_count=MAX_FAIL, Fout=1, locked_out=1, timer=LOCK_CYCLES-1, go to LOCKOUT.
- PASS/FAIL: Tout/Fout held until the next press event.
  - Any press clears Tout, Fout, digits and entry_count, then returns to IDLE.
  - That press is consumed and not stored.
- LOCKOUT:
  - All press events are ignored; timer decrements by 1 per cycle.
  - At timer==0: locked_out=0, Fout=0, fail_count=0, digits=0, entry_count=0, go to IDLE.
  - Total lockout is exactly LOCK_CYCLES cycles.
- Illegal state encoding: recover to IDLE with the full reset values on the next clk.
- Reset asserted mid-operation: immediate return to reset values regardless of state. A key still held at reset release does not generate a press, because key_d reloads before acting.
- Timer width is clog2(LOCK_CYCLES+1). fail_count saturates at MAX_FAIL.

Optional Feature:
CODE_PROG_EN
- Defined:
  - The stored code is a CODE_LEN*4 register loaded with PWD on reset.
  - In PASS, an enter (11) press moves to PROG, clearing digits/entry_count and holding Tout=1.
  - PROG accepts digits and clear exactly as ENTRY does.
  - Enter with entry_count==CODE_LEN copies digits into the stored code, clears Tout, buffer and count, and goes to IDLE.
  - Clear followed by enter in PROG with an incomplete buffer is ignored.
- Undefined: the stored code is the constant PWD, and enter in PASS behaves as any other key (clears and returns to IDLE).

Test Plan:
- Reset, press 2,0,7,2 then 11 (defaults) -> entry_count 1..4, digits=16'h2702, Tout=1/Fout=0 exactly 2 cycles after the enter press edge; next key clears to 0.
- Hold key 5 high for 50 cycles, then release and press 5 again -> entry_count goes 0->1->2 only, slots 0 and 1 =5.
- Press 1,1,1 then 11, then 1 then 10 -> enter with count 3 ignored (Tout=Fout=0), count=4 after the fourth digit, clear gives digits=0, entry_count=0.
- Three wrong 4-digit codes with enter (MAX_FAIL=3) -> fail_count 1,2; the third gives locked_out=1, Fout=1; presses during lockout ignored; after exactly 1024 cycles locked_out=0, fail_count=0.
- Fail once, then enter the correct code -> fail_count returns to 0, Tout=1; assert rst mid-entry with 2 digits entered -> all outputs 0 immediately.
- CODE_PROG_EN defined: unlock, press 11, program 9,9,9,9 then 11, then enter 2,0,7,2 then 11 -> Fout=1; enter 9,9,9,9 then 11 -> Tout=1.
